ripple_carry_adder: RTL and testbench



---
 rtl/rca_pkg.sv | 25 ++
 rtl/ripple_carry_adder_full_adder.sv | 19 +
 rtl/ripple_carry_adder.sv | 65 ++++++
 tb/tb_ripple_carry_adder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the registered ripple-carry adder.
package rca_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 8;
  localparam int unsigned RCA_MAX_WIDTH     = 64;

  // Reference result of a + b + cin at the given width, returned as
  // {carry, sum} in the low width+1 bits. Operands are truncated to width
  // bits first, so callers may pass zero-extended or wider values.
  function automatic logic [64:0] ref_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        cin,
    input int unsigned width
  );
    logic [63:0] opnd_mask;
    logic [64:0] res_mask;
    logic [64:0] full;
    opnd_mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    res_mask  = (width >= 64) ? '1 : ((65'd1 << (width + 1)) - 65'd1);
    full = {1'b0, a & opnd_mask} + {1'b0, b & opnd_mask} + {64'd0, cin};
    return full & res_mask;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder; one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Sum and carry for one bit position.
  always_comb begin
    p  = a ^ b;
    s  = p ^ ci;
    co = (a & b) | (ci & p);
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered N-bit ripple-carry adder: {cout, sum} <= a + b + cin,
// one cycle latency, result held while in_valid is low.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Output register: capture only on valid input so idle (possibly X)
  // operands never reach sum/cout; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

  a_result : assert property (@(posedge clk)
    (rst_n && in_valid) |=>
      (out_valid && (65'({cout, sum}) ==
        ref_add(64'($past(a)), 64'($past(b)), $past(cin), WIDTH))));

  a_reset : assert property (@(posedge clk)
    !rst_n |=> (!out_valid && (sum == '0) && !cout));

  a_hold : assert property (@(posedge clk)
    (rst_n && !in_valid) |=> (!out_valid && $stable(sum) && $stable(cout)));

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH = 8, 1 and 16.
module tb_ripple_carry_adder;
  import rca_pkg::*;

  typedef struct packed {
    logic        v;
    logic        c;
    logic [63:0] s;
  } exp_t;
  typedef exp_t [2:0] exp_row_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv [3];
  logic [63:0] ia [3];
  logic [63:0] ib [3];
  logic        ic [3];

  logic [7:0]  s8;
  logic [0:0]  s1;
  logic [15:0] s16;
  logic        ov8, ov1, ov16, co8, co1, co16;

  logic [63:0] so  [3];
  logic        ovv [3];
  logic        cov [3];

  // expected-value model state
  logic [63:0] hs [3];
  logic        hc [3];
  logic [63:0] ps [3];
  logic        pc [3];

  exp_row_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  assign so[0]  = {56'd0, s8};
  assign so[1]  = {63'd0, s1};
  assign so[2]  = {48'd0, s16};
  assign ovv[0] = ov8;
  assign ovv[1] = ov1;
  assign ovv[2] = ov16;
  assign cov[0] = co8;
  assign cov[1] = co1;
  assign cov[2] = co16;

  ripple_carry_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .a(ia[0][7:0]), .b(ib[0][7:0]),
    .cin(ic[0]), .out_valid(ov8), .sum(s8), .cout(co8)
  );

  ripple_carry_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .a(ia[1][0:0]), .b(ib[1][0:0]),
    .cin(ic[1]), .out_valid(ov1), .sum(s1), .cout(co1)
  );

  ripple_carry_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .a(ia[2][15:0]), .b(ib[2][15:0]),
    .cin(ic[2]), .out_valid(ov16), .sum(s16), .cout(co16)
  );

  function automatic int unsigned wd(input int d);
    case (d)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL w%0d %s got=%h want=%h t=%0t", wd(d), name, got, want, $time);
    end
  endtask

  // Monitor: one expectation row per issued cycle, compared at negedge.
  always @(negedge clk) begin
    exp_row_t row;
    if (q.size() > 0) begin
      row = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        check("out_valid", d, {63'd0, ovv[d]}, {63'd0, row[d].v});
        check("sum",       d, so[d],           row[d].s);
        check("cout",      d, {63'd0, cov[d]}, {63'd0, row[d].c});
      end
    end else begin
      for (int d = 0; d < 3; d++)
        if (ovv[d] === 1'b1) check("unexpected_out_valid", d, 64'd1, 64'd0);
    end
  end

  task automatic drive(input int d, input logic [63:0] x, input logic [63:0] y,
                       input logic c, input logic [63:0] es, input logic ec);
    iv[d] = 1'b1;
    ia[d] = x;
    ib[d] = y;
    ic[d] = c;
    ps[d] = es;
    pc[d] = ec;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ia[d] = 'x;
      ib[d] = 'x;
      ic[d] = 1'bx;
    end
  endtask

  // Push this cycle's expectations, clock once, then idle every input.
  task automatic tick();
    exp_row_t row;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        hs[d] = '0;
        hc[d] = 1'b0;
        row[d].v = 1'b0;
      end else if (iv[d] === 1'b1) begin
        hs[d] = ps[d];
        hc[d] = pc[d];
        row[d].v = 1'b1;
      end else begin
        row[d].v = 1'b0;
      end
      row[d].s = hs[d];
      row[d].c = hc[d];
    end
    q.push_back(row);
    @(posedge clk);
    #1;
    idle_all();
  endtask

  vec_t dir [12];

  initial begin
    logic [64:0] r;
    logic [63:0] x, y, m;
    logic        c;

    dir = '{
      '{8'd2,   8'd3,   1'b0, 8'd5,   1'b0},
      '{8'd2,   8'd4,   1'b1, 8'd7,   1'b0},
      '{8'd5,   8'd5,   1'b0, 8'd10,  1'b0},
      '{8'd9,   8'd1,   1'b1, 8'd11,  1'b0},
      '{8'd7,   8'd2,   1'b1, 8'd10,  1'b0},
      '{8'd2,   8'd2,   1'b1, 8'd5,   1'b0},
      '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1},
      '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1},
      '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0},
      '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1},
      '{8'hFF,  8'h00,  1'b1, 8'd0,   1'b1},
      '{8'd100, 8'd27,  1'b0, 8'd127, 1'b0}
    };

    for (int d = 0; d < 3; d++) begin
      hs[d] = '0; hc[d] = 1'b0; ps[d] = '0; pc[d] = 1'b0;
    end
    idle_all();
    rst_n = 1'b0;

    // reset held with a valid, carry-producing operand pair present
    for (int k = 0; k < 3; k++) begin
      drive(0, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1);
      tick();
    end
    rst_n = 1'b1;

    // directed width-8 vectors, back-to-back; wider/narrower edge cases alongside
    for (int k = 0; k < 12; k++) begin
      drive(0, {56'd0, dir[k].a}, {56'd0, dir[k].b}, dir[k].ci,
            {56'd0, dir[k].s}, dir[k].co);
      if (k == 0) drive(1, 64'd1, 64'd1, 1'b1, 64'd1, 1'b1);
      if (k == 1) drive(1, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0);
      if (k == 2) drive(2, 64'hFFFF, 64'h0000, 1'b1, 64'h0000, 1'b1);
      if (k == 3) drive(2, 64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1);
      if (k == 4) drive(2, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0);
      tick();
    end

    // valid gating: idle operands 9+9 must not disturb the held 5
    drive(0, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0);
    tick();
    ia[0] = 64'd9;
    ib[0] = 64'd9;
    ic[0] = 1'b0;
    tick();
    drive(0, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0);
    tick();

    // reset between valid inputs, then recovery
    drive(0, 64'd10, 64'd20, 1'b0, 64'd30, 1'b0);
    drive(2, 64'd1000, 64'd24, 1'b1, 64'd1025, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(0, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(0, 64'd4, 64'd4, 1'b0, 64'd8, 1'b0);
    drive(1, 64'd0, 64'd1, 1'b0, 64'd1, 1'b0);
    tick();

    // random vectors on all three widths, with occasional idle cycles
    for (int k = 0; k < 1000; k++) begin
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(7) != 0) begin
          m = (64'd1 << wd(d)) - 64'd1;
          x = {$urandom, $urandom} & m;
          y = {$urandom, $urandom} & m;
          c = 1'($urandom_range(1));
          r = ref_add(x, y, c, wd(d));
          drive(d, x, y, c, r[63:0] & m, r[wd(d)]);
        end
      end
      tick();
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) check("drain_timeout", 0, 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
